// File: rtl/onehot_pulse_decoder_if.sv
// Handshake and output bundle for onehot_pulse_decoder.
// The master side drives requests; the slave side is the decoder itself.
interface onehot_pulse_decoder_if #(
    parameter int SEL_W = 3
) ();
    logic                  en;
    logic                  in_valid;
    logic                  in_ready;
    logic [SEL_W-1:0]      sel;
    logic [(2**SEL_W)-1:0] out_onehot;
    logic                  out_valid;
    logic                  busy;
    logic                  done;

    modport master (
        output en, in_valid, sel,
        input  in_ready, out_onehot, out_valid, busy, done
    );

    modport slave (
        input  en, in_valid, sel,
        output in_ready, out_onehot, out_valid, busy, done
    );
endinterface

// File: rtl/onehot_pulse_decoder.sv
// Sequential 3-to-8 decoder: accepts an encoded index and drives its one-hot line for
// PULSE_LEN cycles, then GAP_LEN idle cycles. ONEHOT_PULSE_QUEUE_EN adds a one-entry request buffer.
module onehot_pulse_decoder #(
    parameter int SEL_W     = 3,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1,
    parameter int CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    onehot_pulse_decoder_if.slave  bus
);
    localparam int N_OUT     = 2**SEL_W;
    localparam int PULSE_EFF = (PULSE_LEN < 1) ? 1 : PULSE_LEN;
    localparam bit HAS_GAP   = (GAP_LEN > 0);

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_EFF - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(HAS_GAP ? GAP_LEN - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SEL_W-1:0]   r_sel;
    logic [N_OUT-1:0]   r_onehot;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_done;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_pend_valid;
    logic [SEL_W-1:0]   w_pend_sel;
    logic               w_slot;
    logic               w_launch;

`ifdef ONEHOT_PULSE_QUEUE_EN
    logic               r_buf_full;
    logic [SEL_W-1:0]   r_buf_sel;
`endif

    function automatic logic [N_OUT-1:0] f_decode(input logic [SEL_W-1:0] idx);
        f_decode = {{(N_OUT-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Handshake, pending-request selection and the "may start a new pulse" slot
    always_comb begin
        w_in_ready   = 1'b0;
        w_accept     = 1'b0;
        w_pend_valid = 1'b0;
        w_pend_sel   = {SEL_W{1'b0}};
        w_slot       = 1'b0;
`ifdef ONEHOT_PULSE_QUEUE_EN
        w_in_ready   = bus.en && !r_buf_full;
        w_accept     = bus.in_valid && w_in_ready;
        w_pend_valid = r_buf_full || w_accept;
        if (r_buf_full) begin
            w_pend_sel = r_buf_sel;
        end else begin
            w_pend_sel = bus.sel;
        end
`else
        w_in_ready   = bus.en && (r_state == ST_IDLE);
        w_accept     = bus.in_valid && w_in_ready;
        w_pend_valid = w_accept;
        w_pend_sel   = bus.sel;
`endif
        // A slot is the edge at which the block would otherwise fall back to IDLE
        case (r_state)
            ST_IDLE:  w_slot = 1'b1;
            ST_DRIVE: w_slot = bus.en && (r_cnt == CNT_ZERO) && !HAS_GAP;
            ST_GAP:   w_slot = (r_cnt == CNT_ZERO);
            default:  w_slot = 1'b0;
        endcase
        w_launch = w_slot && w_pend_valid;
    end

    // Main FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= CNT_ZERO;
            r_sel       <= {SEL_W{1'b0}};
            r_onehot    <= {N_OUT{1'b0}};
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_state     <= ST_DRIVE;
                        r_cnt       <= PULSE_LOAD;
                        r_sel       <= w_pend_sel;
                        r_onehot    <= f_decode(w_pend_sel);
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= (PULSE_LOAD == CNT_ZERO);
                    end else begin
                        r_onehot    <= {N_OUT{1'b0}};
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (!bus.en) begin
                        r_state     <= ST_IDLE;
                        r_cnt       <= CNT_ZERO;
                        r_onehot    <= {N_OUT{1'b0}};
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b0;
                    end else if (r_cnt != CNT_ZERO) begin
                        r_cnt       <= r_cnt - CNT_ONE;
                        r_onehot    <= f_decode(r_sel);
                        r_done      <= (r_cnt == CNT_ONE);
                    end else if (HAS_GAP) begin
                        r_state     <= ST_GAP;
                        r_cnt       <= GAP_LOAD;
                        r_onehot    <= {N_OUT{1'b0}};
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                    end else if (w_launch) begin
                        r_cnt       <= PULSE_LOAD;
                        r_sel       <= w_pend_sel;
                        r_onehot    <= f_decode(w_pend_sel);
                        r_out_valid <= 1'b1;
                        r_done      <= (PULSE_LOAD == CNT_ZERO);
                    end else begin
                        r_state     <= ST_IDLE;
                        r_onehot    <= {N_OUT{1'b0}};
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b0;
                    end
                end
                ST_GAP: begin
                    // en does not shorten the gap; only the counter ends it
                    if (r_cnt != CNT_ZERO) begin
                        r_cnt       <= r_cnt - CNT_ONE;
                    end else if (w_launch) begin
                        r_state     <= ST_DRIVE;
                        r_cnt       <= PULSE_LOAD;
                        r_sel       <= w_pend_sel;
                        r_onehot    <= f_decode(w_pend_sel);
                        r_out_valid <= 1'b1;
                        r_done      <= (PULSE_LOAD == CNT_ZERO);
                    end else begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= CNT_ZERO;
                    r_onehot    <= {N_OUT{1'b0}};
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

`ifdef ONEHOT_PULSE_QUEUE_EN
    // One-entry request buffer: filled by accepts that cannot launch, drained at the next slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buf_full <= 1'b0;
            r_buf_sel  <= {SEL_W{1'b0}};
        end else if ((r_state == ST_DRIVE) && !bus.en) begin
            r_buf_full <= 1'b0;
        end else if (w_launch && r_buf_full) begin
            r_buf_full <= 1'b0;
        end else if (w_accept && !w_launch) begin
            r_buf_full <= 1'b1;
            r_buf_sel  <= bus.sel;
        end else begin
            r_buf_full <= r_buf_full;
        end
    end
`endif

    assign bus.in_ready   = w_in_ready;
    assign bus.out_onehot = r_onehot;
    assign bus.out_valid  = r_out_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Directed bench for onehot_pulse_decoder: a default-parameter instance and a
// PULSE_LEN=0/GAP_LEN=0 corner instance share clock and reset.
module tb_onehot_pulse_decoder;
`ifdef ONEHOT_PULSE_QUEUE_EN
    localparam int SP = 5;
`else
    localparam int SP = 6;
`endif

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    onehot_pulse_decoder_if #(.SEL_W(3)) bus_a ();
    onehot_pulse_decoder_if #(.SEL_W(3)) bus_c ();

    onehot_pulse_decoder #(.SEL_W(3), .PULSE_LEN(4), .GAP_LEN(1), .CNT_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    onehot_pulse_decoder #(.SEL_W(3), .PULSE_LEN(0), .GAP_LEN(0), .CNT_W(8)) u_dut_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_oh;
        logic       acc;
        int         sent;
        n_pass  = 0;
        n_total = 0;

        rst_n = 1'b0;
        bus_a.en = 1'b1; bus_a.in_valid = 1'b0; bus_a.sel = 3'd0;
        bus_c.en = 1'b1; bus_c.in_valid = 1'b0; bus_c.sel = 3'd0;
        tick();
        tick();
        chk("rst_onehot", 32'(bus_a.out_onehot), 32'h00);
        chk("rst_valid",  32'(bus_a.out_valid),  32'd0);
        chk("rst_busy",   32'(bus_a.busy),       32'd0);
        chk("rst_done",   32'(bus_a.done),       32'd0);
        chk("rst_c_onehot", 32'(bus_c.out_onehot), 32'h00);
        rst_n = 1'b1;
        tick();
        chk("idle_onehot", 32'(bus_a.out_onehot), 32'h00);
        chk("idle_busy",   32'(bus_a.busy),       32'd0);
        chk("idle_ready",  32'(bus_a.in_ready),   32'd1);

        // Single request sel=5
        bus_a.sel = 3'b101; bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("single_oh_%0d", k),   32'(bus_a.out_onehot), 32'h20);
            chk($sformatf("single_done_%0d", k), 32'(bus_a.done), (k == 4) ? 32'd1 : 32'd0);
            chk($sformatf("single_busy_%0d", k), 32'(bus_a.busy), 32'd1);
            tick();
        end
        chk("gap_onehot", 32'(bus_a.out_onehot), 32'h00);
        chk("gap_valid",  32'(bus_a.out_valid),  32'd0);
        chk("gap_busy",   32'(bus_a.busy),       32'd1);
        tick();
        chk("after_ready", 32'(bus_a.in_ready), 32'd1);
        chk("after_busy",  32'(bus_a.busy),     32'd0);

        // Back-to-back sweep of sel=0..7 with in_valid held high
        sent = 0;
        bus_a.sel = 3'd0; bus_a.in_valid = 1'b1;
        for (int t = 1; t <= 8 * SP; t++) begin
            #1;
            acc = bus_a.in_valid && bus_a.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                if (sent == 8) begin
                    bus_a.in_valid = 1'b0;
                end else begin
                    bus_a.sel = 3'(sent);
                end
            end
            if (((t - 1) % SP) < 4) exp_oh = 8'h01 << ((t - 1) / SP);
            else exp_oh = 8'h00;
            chk($sformatf("sweep_oh_t%0d", t), 32'(bus_a.out_onehot), 32'(exp_oh));
            chk($sformatf("sweep_valid_t%0d", t), 32'(bus_a.out_valid), (exp_oh != 8'h00) ? 32'd1 : 32'd0);
        end
        chk("sweep_sent", 32'(sent), 32'd8);
        tick();
        tick();
        chk("sweep_idle_busy", 32'(bus_a.busy), 32'd0);

        // Abort: drop en on the second DRIVE cycle
        bus_a.sel = 3'b010; bus_a.in_valid = 1'b1;
        tick();
        bus_a.in_valid = 1'b0;
        chk("abort_drive1", 32'(bus_a.out_onehot), 32'h04);
        tick();
        chk("abort_drive2", 32'(bus_a.out_onehot), 32'h04);
        bus_a.en = 1'b0;
        tick();
        chk("abort_onehot", 32'(bus_a.out_onehot), 32'h00);
        chk("abort_done",   32'(bus_a.done),       32'd0);
        chk("abort_busy",   32'(bus_a.busy),       32'd0);
        chk("abort_ready",  32'(bus_a.in_ready),   32'd0);
        bus_a.in_valid = 1'b1;
        tick();
        chk("abort_ign_onehot", 32'(bus_a.out_onehot), 32'h00);
        chk("abort_ign_done",   32'(bus_a.done),       32'd0);
        chk("abort_ready2",     32'(bus_a.in_ready),   32'd0);
        bus_a.in_valid = 1'b0;
        bus_a.en = 1'b1;
        #1;
        chk("abort_ready_en", 32'(bus_a.in_ready), 32'd1);

        // Corner instance: one-cycle pulse, no gap
        bus_c.sel = 3'b111; bus_c.in_valid = 1'b1;
        tick();
        bus_c.in_valid = 1'b0;
        chk("corner_onehot", 32'(bus_c.out_onehot), 32'h80);
        chk("corner_done",   32'(bus_c.done),       32'd1);
        chk("corner_valid",  32'(bus_c.out_valid),  32'd1);
        tick();
        chk("corner_onehot2", 32'(bus_c.out_onehot), 32'h00);
        chk("corner_done2",   32'(bus_c.done),       32'd0);
        chk("corner_busy2",   32'(bus_c.busy),       32'd0);
        chk("corner_ready2",  32'(bus_c.in_ready),   32'd1);

        // Reset mid-pulse; a second request is offered so a queue build has its buffer filled
        bus_a.sel = 3'b001; bus_a.in_valid = 1'b1;
        tick();
        bus_a.sel = 3'b110;
        chk("rmid_drive1", 32'(bus_a.out_onehot), 32'h02);
        tick();
        bus_a.in_valid = 1'b0;
        chk("rmid_drive2", 32'(bus_a.out_onehot), 32'h02);
        rst_n = 1'b0;
        tick();
        chk("rmid_onehot", 32'(bus_a.out_onehot), 32'h00);
        chk("rmid_valid",  32'(bus_a.out_valid),  32'd0);
        chk("rmid_busy",   32'(bus_a.busy),       32'd0);
        chk("rmid_done",   32'(bus_a.done),       32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rmid_quiet_%0d", k), 32'(bus_a.out_onehot), 32'h00);
        end
        chk("rmid_ready", 32'(bus_a.in_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
